// File: rtl/osd_pkg.sv
// osd_pkg: shared command codes, line geometry and FSM state type for the OSD SPI front end.
package osd_pkg;
    localparam logic [3:0] OSD_CMD_WRITE  = 4'h2;
    localparam logic [3:0] OSD_CMD_ENABLE = 4'h4;
    localparam int         OSD_LINE_BYTES = 256;
    typedef enum logic [1:0] {IDLE, CMD, PAYLOAD, IGNORE} state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: brings SCK/SS3/DI into clk_sys and flags SCK rising edges.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic i_sck,
    input  logic i_ss,
    input  logic i_di,
    output logic o_sck_rise,
    output logic o_ss,
    output logic o_di
);
    logic [SYNC_STAGES-1:0] r_sck, r_ss, r_di;
    logic r_sck_d, r_rise, r_ss_o, r_di_o;

    // Rise, SS and DI leave through one common register so all three stay aligned.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sck   <= '0;
            r_ss    <= '0;
            r_di    <= '0;
            r_sck_d <= 1'b0;
            r_rise  <= 1'b0;
            r_ss_o  <= 1'b0;
            r_di_o  <= 1'b0;
        end else begin
            r_sck   <= {r_sck[SYNC_STAGES-2:0], i_sck};
            r_ss    <= {r_ss[SYNC_STAGES-2:0], i_ss};
            r_di    <= {r_di[SYNC_STAGES-2:0], i_di};
            r_sck_d <= r_sck[SYNC_STAGES-1];
            r_rise  <= r_sck[SYNC_STAGES-1] & ~r_sck_d;
            r_ss_o  <= r_ss[SYNC_STAGES-1];
            r_di_o  <= r_di[SYNC_STAGES-1];
        end
    end

    assign o_sck_rise = r_rise;
    assign o_ss       = r_ss_o;
    assign o_di       = r_di_o;
endmodule

// File: rtl/osd_spi_cmd.sv
// osd_spi_cmd: oversampled SPI command decoder producing OSD buffer writes and the enable level.
module osd_spi_cmd
    import osd_pkg::*;
#(
    parameter  int OSD_LINES   = 16,
    parameter  int SYNC_STAGES = 2,
    localparam int AW          = 8 + $clog2(OSD_LINES)
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          SPI_SCK,
    input  logic          SPI_SS3,
    input  logic          SPI_DI,
    output logic          osd_enable,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          cmd_valid,
    output logic [7:0]    cmd,
    output logic          busy
);
    localparam int LINE_SHIFT = $clog2(OSD_LINE_BYTES);

    logic          w_sck_rise, w_ss, w_di;
    logic          r_ss_prev, r_done;
    logic [2:0]    r_cnt;
    logic [7:0]    r_shift;
    logic [AW-1:0] r_addr, w_line_base;
    state_t        r_state, w_next;
    logic          w_cmd_done, w_wr;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .i_sck      (SPI_SCK),
        .i_ss       (SPI_SS3),
        .i_di       (SPI_DI),
        .o_sck_rise (w_sck_rise),
        .o_ss       (w_ss),
        .o_di       (w_di)
    );

    // Truncation to AW bits keeps only the low line-number bits (line mod OSD_LINES).
    assign w_line_base = AW'({r_shift[3:0], {LINE_SHIFT{1'b0}}});

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= 3'd0;
            r_shift <= 8'd0;
            r_done  <= 1'b0;
        end else if (w_ss || r_state == IDLE) begin
            r_cnt  <= 3'd0;
            r_done <= 1'b0;
        end else if (w_sck_rise) begin
            r_shift <= {r_shift[6:0], w_di};
            r_cnt   <= r_cnt + 3'd1;
            r_done  <= (r_cnt == 3'd7);
        end else begin
            r_done <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_ss_prev <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ss_prev <= w_ss;
        end
    end

    // Entry to CMD needs an observed high-to-low SS3 transition, so a frame already running at reset release is skipped.
    always_comb begin
        w_next     = r_state;
        w_cmd_done = 1'b0;
        w_wr       = 1'b0;
        if (w_ss) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_next = r_ss_prev ? CMD : IDLE;
                CMD: begin
                    w_cmd_done = r_done;
                    if (r_done)
                        w_next = (r_shift[7:4] == OSD_CMD_WRITE) ? PAYLOAD : IGNORE;
                end
                PAYLOAD: w_wr = r_done;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            osd_enable <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'd0;
            cmd_valid  <= 1'b0;
            cmd        <= 8'd0;
            busy       <= 1'b0;
            r_addr     <= '0;
        end else begin
            busy      <= ~w_ss;
            cmd_valid <= w_cmd_done;
            wr_en     <= w_wr;
            if (w_cmd_done) begin
                cmd <= r_shift;
                if (r_shift[7:4] == OSD_CMD_ENABLE)
                    osd_enable <= r_shift[0];
                if (r_shift[7:4] == OSD_CMD_WRITE)
                    r_addr <= w_line_base;
            end
            if (w_wr) begin
                wr_data <= r_shift;
                wr_addr <= r_addr;
                r_addr  <= r_addr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_osd_spi_cmd.sv
// tb_osd_spi_cmd: directed SPI frames against osd_spi_cmd with hand-computed writes, commands and latency.
module tb_osd_spi_cmd;
    localparam int SS  = 2;
    localparam int LAT = SS + 3;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        SPI_SCK = 1'b0;
    logic        SPI_SS3 = 1'b1;
    logic        SPI_DI  = 1'b0;
    logic        osd_enable, wr_en, cmd_valid, busy;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data, cmd;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [11:0] wa_q[$];
    logic [7:0]  wd_q[$];
    logic [7:0]  c_q[$];
    int          wt_q[$];
    int          ct_q[$];
    int          rt_q[$];

    osd_spi_cmd #(.OSD_LINES(16), .SYNC_STAGES(SS)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .SPI_SCK    (SPI_SCK),
        .SPI_SS3    (SPI_SS3),
        .SPI_DI     (SPI_DI),
        .osd_enable (osd_enable),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .busy       (busy)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            wt_q.push_back(cyc);
        end
        if (cmd_valid) begin
            c_q.push_back(cmd);
            ct_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        wa_q.delete();
        wd_q.delete();
        wt_q.delete();
        c_q.delete();
        ct_q.delete();
        rt_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] v, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk_sys);
            #1 SPI_SCK = 1'b0;
            SPI_DI = v[7-i];
            @(posedge clk_sys);
            @(posedge clk_sys);
            #1 SPI_SCK = 1'b1;
            if (i == 7) rt_q.push_back(cyc);
            @(posedge clk_sys);
        end
        @(posedge clk_sys);
        #1 SPI_SCK = 1'b0;
    endtask

    task automatic frame_start();
        @(posedge clk_sys);
        #1 SPI_SS3 = 1'b0;
        repeat (5) @(posedge clk_sys);
        #1;
    endtask

    task automatic frame_end();
        repeat (4) @(posedge clk_sys);
        #1 SPI_SS3 = 1'b1;
        repeat (8) @(posedge clk_sys);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk_sys);
        #1 check("reset_outputs", {osd_enable, wr_en, wr_addr, wr_data, cmd_valid, cmd, busy}, 32'd0);
        reset_n = 1'b1;
        repeat (8) @(posedge clk_sys);
        #1 check("idle_busy", {31'd0, busy}, 32'd0);

        clear_q();
        frame_start();
        check("frame_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h41, 8);
        frame_end();
        check("en41_level", {31'd0, osd_enable}, 32'd1);
        check("en41_ncmd", c_q.size(), 32'd1);
        check("en41_cmd", {24'd0, c_q[0]}, 32'h41);
        check("en41_lat", ct_q[0] - rt_q[0], LAT);
        check("en41_nwr", wa_q.size(), 32'd0);
        clear_q();
        frame_start();
        send_byte(8'h40, 8);
        frame_end();
        check("en40_level", {31'd0, osd_enable}, 32'd0);
        check("en40_ncmd", c_q.size(), 32'd1);
        check("en40_cmd", {24'd0, c_q[0]}, 32'h40);
        check("en40_nwr", wa_q.size(), 32'd0);

        clear_q();
        frame_start();
        send_byte(8'h23, 8);
        send_byte(8'hAA, 8);
        send_byte(8'h55, 8);
        send_byte(8'h0F, 8);
        frame_end();
        check("w23_ncmd", c_q.size(), 32'd1);
        check("w23_cmd", {24'd0, c_q[0]}, 32'h23);
        check("w23_nwr", wa_q.size(), 32'd3);
        check("w23_a0", {20'd0, wa_q[0], wd_q[0]}, 32'h300AA);
        check("w23_a1", {20'd0, wa_q[1], wd_q[1]}, 32'h30155);
        check("w23_a2", {20'd0, wa_q[2], wd_q[2]}, 32'h3020F);
        for (int k = 0; k < 3; k++) check("w23_lat", wt_q[k] - rt_q[k+1], LAT);
        check("w23_hold", {20'd0, wr_addr, wr_data}, 32'h3020F);

        clear_q();
        frame_start();
        send_byte(8'h21, 8);
        send_byte(8'hC3, 8);
        send_byte(8'hA5, 5);
        frame_end();
        check("abort_nwr", wa_q.size(), 32'd1);
        check("abort_w0", {20'd0, wa_q[0], wd_q[0]}, 32'h100C3);
        check("abort_ncmd", c_q.size(), 32'd1);
        clear_q();
        frame_start();
        send_byte(8'h41, 8);
        frame_end();
        check("after_abort_cmd", {24'd0, c_q[0]}, 32'h41);
        check("after_abort_en", {31'd0, osd_enable}, 32'd1);
        check("after_abort_nwr", wa_q.size(), 32'd0);

        clear_q();
        frame_start();
        send_byte(8'h80, 8);
        send_byte(8'h11, 8);
        send_byte(8'h22, 8);
        frame_end();
        check("c80_ncmd", c_q.size(), 32'd1);
        check("c80_cmd", {24'd0, c_q[0]}, 32'h80);
        check("c80_nwr", wa_q.size(), 32'd0);
        check("c80_en", {31'd0, osd_enable}, 32'd1);

        clear_q();
        frame_start();
        send_byte(8'h2F, 8);
        for (int k = 0; k < 257; k++) send_byte(k[7:0] ^ 8'h5A, 8);
        frame_end();
        check("wrap_nwr", wa_q.size(), 32'd257);
        for (int k = 0; k < 257; k++) begin
            logic [11:0] ea;
            logic [7:0]  ed;
            ea = 12'hF00 + k[11:0];
            ed = k[7:0] ^ 8'h5A;
            check("wrap_w", {20'd0, wa_q[k], wd_q[k]}, {20'd0, ea, ed});
        end

        clear_q();
        frame_start();
        send_byte(8'h22, 8);
        send_byte(8'hFF, 4);
        @(posedge clk_sys);
        #3 reset_n = 1'b0;
        #1 check("async_reset", {osd_enable, wr_en, wr_addr, wr_data, cmd_valid, cmd, busy}, 32'd0);
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        clear_q();
        send_byte(8'h99, 8);
        send_byte(8'h24, 8);
        frame_end();
        check("post_reset_nwr", wa_q.size(), 32'd0);
        check("post_reset_ncmd", c_q.size(), 32'd0);
        clear_q();
        frame_start();
        send_byte(8'h22, 8);
        send_byte(8'h7E, 8);
        frame_end();
        check("rst_frame_nwr", wa_q.size(), 32'd1);
        check("rst_frame_w0", {20'd0, wa_q[0], wd_q[0]}, 32'h2007E);
        check("rst_frame_lat", wt_q[0] - rt_q[1], LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
